mem_wb_stage: RTL

- MEM/WB pipeline stage of the 5-stage RV32I core; sits directly downstream of the memory stage and consumes its DM_read_data and ALUOut.
- Performs load-data lane extraction and sign/zero extension, selects the write-back source, and registers the result for the register-file write port and forwarding unit.
- Also maintains a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register of the RV32I core.
// Extracts and extends load data, selects the write-back source and
// registers the result for the register-file write port and forwarding.
// Also counts retired instructions.
//
// Optional feature macro: MEM_WB_MISALIGN_CHECK_EN
//   defined   -> misaligned LH/LHU/LW captures set wb_misalign and
//                suppress wb_regWrite
//   undefined -> wb_misalign is tied to 0
//
// Ports:
//   clk, start        clock, synchronous active-high reset
//   stall, flush      hold stage / insert bubble (start > flush > stall)
//   in_valid ...      instruction fields from the memory stage
//   ALUOut            ALU result, also the load byte address
//   DM_read_data      aligned data-memory word
//   pc_plus4_in       link value
//   wb_*              registered write-back outputs
//   retired_count     instructions retired since reset (wraps)
//   wb_misalign       misaligned-load flag
module mem_wb_stage #(
   parameter int unsigned width      = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  start,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic                  regWrite_in,
   input  logic [1:0]            wbSel_in,
   input  logic [2:0]            funct3_in,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic [width-1:0]      ALUOut,
   input  logic [width-1:0]      DM_read_data,
   input  logic [width-1:0]      pc_plus4_in,
   output logic                  wb_valid,
   output logic                  wb_regWrite,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [width-1:0]      wb_data,
   output logic [31:0]           retired_count,
   output logic                  wb_misalign
);

   logic [7:0]       byte_sel_c;
   logic [15:0]      half_sel_c;
   logic [width-1:0] load_data_c;
   logic [width-1:0] wb_mux_c;
   logic             misalign_c;
   logic             unused_addr_bits;

   // Only the two low address bits matter for lane selection.
   assign unused_addr_bits = ^ALUOut[width-1:2];

   // Lane selection and sign/zero extension of the load word.
   always_comb begin
      byte_sel_c  = DM_read_data[7:0];
      half_sel_c  = DM_read_data[15:0];
      load_data_c = DM_read_data;
      case (ALUOut[1:0])
         2'b00:   byte_sel_c = DM_read_data[7:0];
         2'b01:   byte_sel_c = DM_read_data[15:8];
         2'b10:   byte_sel_c = DM_read_data[23:16];
         default: byte_sel_c = DM_read_data[31:24];
      endcase
      half_sel_c = ALUOut[1] ? DM_read_data[31:16] : DM_read_data[15:0];
      case (funct3_in)
         3'b000:  load_data_c = {{(width-8){byte_sel_c[7]}}, byte_sel_c};
         3'b001:  load_data_c = {{(width-16){half_sel_c[15]}}, half_sel_c};
         3'b100:  load_data_c = {{(width-8){1'b0}}, byte_sel_c};
         3'b101:  load_data_c = {{(width-16){1'b0}}, half_sel_c};
         default: load_data_c = DM_read_data;
      endcase
   end

   // Write-back source select; 11 aliases the ALU path.
   always_comb begin
      wb_mux_c = ALUOut;
      case (wbSel_in)
         2'b01:   wb_mux_c = load_data_c;
         2'b10:   wb_mux_c = pc_plus4_in;
         default: wb_mux_c = ALUOut;
      endcase
   end

   // Misaligned-load detection (feature-gated).
`ifdef MEM_WB_MISALIGN_CHECK_EN
   always_comb begin
      misalign_c = 1'b0;
      if (wbSel_in == 2'b01) begin
         if ((funct3_in == 3'b001 || funct3_in == 3'b101) && ALUOut[0])
            misalign_c = 1'b1;
         else if (funct3_in == 3'b010 && ALUOut[1:0] != 2'b00)
            misalign_c = 1'b1;
      end
   end
`else
   assign misalign_c = 1'b0;
`endif

   // Stage registers: start > flush > stall > capture.
   always_ff @(posedge clk) begin
      if (start) begin
         wb_valid      <= 1'b0;
         wb_regWrite   <= 1'b0;
         wb_rd         <= '0;
         wb_data       <= '0;
         retired_count <= 32'd0;
         wb_misalign   <= 1'b0;
      end else if (flush) begin
         wb_valid      <= 1'b0;
         wb_regWrite   <= 1'b0;
         wb_rd         <= '0;
         wb_data       <= '0;
         wb_misalign   <= 1'b0;
      end else if (!stall) begin
         wb_valid      <= in_valid;
         // x0 is never written; a misaligned load is dropped.
         wb_regWrite   <= in_valid & regWrite_in & (rd_in != '0) & ~misalign_c;
         wb_rd         <= rd_in;
         wb_data       <= wb_mux_c;
         wb_misalign   <= in_valid & misalign_c;
         if (in_valid)
            retired_count <= retired_count + 32'd1;
      end
   end

endmodule
